// File: rtl/ram_sequencer.sv
// Byte-wide RAM port sequencer: arbitrates fetch and data requesters round-robin
// and splits each 1/2/4/8-byte little-endian access into consecutive byte cycles.
module ram_sequencer #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_add,
  input  logic [1:0]    i_sz,
  output logic          i_gnt,
  output logic          i_done,
  output logic [63:0]   i_q,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_add,
  input  logic [1:0]    d_sz,
  input  logic [63:0]   d_wd,
  output logic          d_gnt,
  output logic          d_done,
  output logic [63:0]   d_q,
  output logic          busy,
  output logic [AW-1:0] ram_add,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester holds req (with its attributes) until it sees its gnt
  // in the same cycle; gnt only rises in IDLE, and attributes are sampled at that edge.
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;      // 1 = data requester
  logic          last_q, last_d;        // 1 = data was granted last
  logic [AW-1:0] base_q, base_d;
  logic [2:0]    last_idx_q, last_idx_d;
  logic          we_q, we_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [63:0]   rbuf_q, rbuf_d;
  logic [63:0]   i_q_q, i_q_d;
  logic [63:0]   d_q_q, d_q_d;
  logic [63:0]   byte_mask;
  logic          grant_f;

  function automatic logic [2:0] last_of(input logic [1:0] sz);
    case (sz)
      2'b00:   last_of = 3'd0;
      2'b01:   last_of = 3'd1;
      2'b10:   last_of = 3'd3;
      default: last_of = 3'd7;
    endcase
  endfunction

  always_comb begin
    byte_mask = '0;
    for (int k = 0; k < 8; k++) begin
      byte_mask[k*8 +: 8] = (3'(k) <= last_idx_q) ? 8'hFF : 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    base_d     = base_q;
    last_idx_d = last_idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    i_q_d      = i_q_q;
    d_q_d      = d_q_q;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    grant_f    = i_req && (!d_req || last_q);
    case (state_q)
      S_IDLE: begin
        if (!rst && (i_req || d_req)) begin
          i_gnt      = grant_f;
          d_gnt      = !grant_f;
          state_d    = S_XFER;
          owner_d    = !grant_f;
          last_d     = !grant_f;
          base_d     = grant_f ? i_add : d_add;
          last_idx_d = last_of(grant_f ? i_sz : d_sz);
          we_d       = !grant_f && d_we;
          wdata_d    = grant_f ? 64'd0 : d_wd;
          cnt_d      = 3'd0;
          rbuf_d     = 64'd0;
        end
      end
      S_XFER: begin
        // Synchronous RAM: the byte addressed last cycle arrives now.
        if (!we_q && cnt_q != 3'd0) begin
          rbuf_d[{cnt_q - 3'd1, 3'b000} +: 8] = ram_q;
        end
        if (cnt_q == last_idx_q) begin
          state_d = we_q ? S_DONE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DRAIN: begin
        rbuf_d[{last_idx_q, 3'b000} +: 8] = ram_q;
        if (owner_q) d_q_d = rbuf_d & byte_mask;
        else         i_q_d = rbuf_d & byte_mask;
        state_d = S_DONE;
      end
      S_DONE: begin
        i_done  = !owner_q;
        d_done  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      base_q     <= '0;
      last_idx_q <= 3'd0;
      we_q       <= 1'b0;
      wdata_q    <= 64'd0;
      cnt_q      <= 3'd0;
      rbuf_q     <= 64'd0;
      i_q_q      <= 64'd0;
      d_q_q      <= 64'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      base_q     <= base_d;
      last_idx_q <= last_idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      i_q_q      <= i_q_d;
      d_q_q      <= d_q_d;
    end
  end

  assign ram_add   = base_q + AW'(cnt_q);
  assign ram_d     = wdata_q[{cnt_q, 3'b000} +: 8];
  assign ram_we    = (state_q == S_XFER) && we_q;
  assign busy      = (state_q != S_IDLE);
  assign i_q       = i_q_q;
  assign d_q       = d_q_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer with a synchronous byte RAM model and
// hand-computed expected values.
module tb_ram_sequencer;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_add = '0;
  logic [1:0]    i_sz = 2'b00;
  logic          i_gnt, i_done;
  logic [63:0]   i_q;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_add = '0;
  logic [1:0]    d_sz = 2'b00;
  logic [63:0]   d_wd = 64'd0;
  logic          d_gnt, d_done;
  logic [63:0]   d_q;
  logic          busy;
  logic [AW-1:0] ram_add;
  logic [7:0]    ram_d;
  logic          ram_we;
  logic [7:0]    ram_q = 8'd0;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  ram_sequencer #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_add(i_add), .i_sz(i_sz), .i_gnt(i_gnt), .i_done(i_done), .i_q(i_q),
    .d_req(d_req), .d_we(d_we), .d_add(d_add), .d_sz(d_sz), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_done(d_done), .d_q(d_q),
    .busy(busy), .ram_add(ram_add), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous RAM model with a bench-side preload port
  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_add = 16'd0;
  logic [7:0]  pre_d = 8'd0;
  always @(posedge clk) begin
    if (pre_we)      mem[pre_add] <= pre_d;
    else if (ram_we) mem[ram_add] <= ram_d;
    ram_q <= mem[ram_add];
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_add = a;
    pre_d   = d;
    pre_we  = 1'b1;
    tick();
    pre_we  = 1'b0;
  endtask

  // One full transaction by a lone requester, checked cycle by cycle.
  task automatic xfer(input bit is_d, input bit we, input logic [15:0] add,
                      input logic [1:0] sz, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input string tag);
    int n;
    int w;
    logic [15:0] a;
    n = 1 << sz;
    w = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_add = add; d_sz = sz; d_wd = wd;
    end else begin
      i_req = 1'b1; i_add = add; i_sz = sz;
    end
    @(negedge clk);
    while (!(is_d ? d_gnt : i_gnt) && w < 20) begin
      tick();
      @(negedge clk);
      w++;
    end
    check({tag, "_gnt"}, {63'd0, (is_d ? d_gnt : i_gnt)}, 64'd1);
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    d_wd  = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = add + 16'(k);
      check({tag, "_add"}, {48'd0, ram_add}, {48'd0, a});
      check({tag, "_we"}, {63'd0, ram_we}, {63'd0, we});
      if (we) check({tag, "_wd"}, {56'd0, ram_d}, {56'd0, wd[k*8 +: 8]});
      tick();
    end
    if (!we) begin
      @(negedge clk);
      a = add + 16'(n);
      check({tag, "_drain_we"}, {63'd0, ram_we}, 64'd0);
      check({tag, "_drain_add"}, {63'd0, (ram_add == a)}, 64'd0);
      check({tag, "_drain_dn"}, {62'd0, i_done, d_done}, 64'd0);
      tick();
    end
    @(negedge clk);
    check({tag, "_done"}, {62'd0, i_done, d_done}, is_d ? 64'd1 : 64'd2);
    check({tag, "_done_we"}, {63'd0, ram_we}, 64'd0);
    check({tag, "_done_busy"}, {63'd0, busy}, 64'd1);
    if (!we) check({tag, "_q"}, is_d ? d_q : i_q, exp_rd);
    tick();
    @(negedge clk);
    check({tag, "_idle"}, {61'd0, busy, i_done, d_done}, 64'd0);
    if (!we) check({tag, "_q_hold"}, is_d ? d_q : i_q, exp_rd);
    tick();
  endtask

  initial begin
    int grants;
    int cyc;
    int last_t;
    int i_dn;
    int d_dn;
    int ab_dn;
    int w;
    int gaps[3];
    int exp_gap[3];
    logic [0:0] exp_owner;
    exp_gap = '{4, 3, 4};

    poke(16'h0020, 8'hAA); poke(16'h0021, 8'hBB); poke(16'h0022, 8'hCC);
    poke(16'h0023, 8'hDD); poke(16'h0024, 8'hEE);
    poke(16'hFFFC, 8'h01); poke(16'hFFFD, 8'h02); poke(16'hFFFE, 8'h03);
    poke(16'h0001, 8'h04); poke(16'h0002, 8'h05); poke(16'h0003, 8'h06);
    for (int k = 3; k < 8; k++) poke(16'h0300 + 16'(k), 8'h00);

    // reset with both requests high
    i_req = 1'b1; i_add = 16'h0020; i_sz = 2'b00;
    d_req = 1'b1; d_we = 1'b1; d_add = 16'h0200; d_sz = 2'b00; d_wd = 64'h5A;
    tick();
    @(negedge clk);
    check("rst_gnt", {62'd0, i_gnt, d_gnt}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ram", {39'd0, ram_we, ram_add, ram_d}, 64'd0);
    check("rst_done", {62'd0, i_done, d_done}, 64'd0);
    check("rst_iq", i_q, 64'd0);
    check("rst_dq", d_q, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    tick();
    rst = 1'b0;

    // continuous simultaneous requests: round-robin starting with fetch
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    grants = 0; cyc = 0; last_t = 0; i_dn = 0; d_dn = 0;
    while (grants < 4 && cyc < 60) begin
      @(negedge clk);
      if (i_done) i_dn++;
      if (d_done) d_dn++;
      if (i_gnt || d_gnt) begin
        check("rr_one_gnt", {62'd0, i_gnt, d_gnt}, d_gnt ? 64'd1 : 64'd2);
        exp_owner = exp_q.pop_front();
        check("rr_owner", {63'd0, d_gnt}, {63'd0, exp_owner});
        if (grants > 0) gaps[grants-1] = cyc - last_t;
        last_t = cyc;
        grants++;
      end
      tick();
      cyc++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("rr_grants", 64'(grants), 64'd4);
    for (int k = 0; k < 3; k++) check("rr_gap", 64'(gaps[k]), 64'(exp_gap[k]));
    check("rr_i_done", 64'(i_dn), 64'd2);
    check("rr_d_done", 64'(d_dn), 64'd1);
    check("rr_iq", i_q, 64'h00000000000000AA);
    w = 0;
    @(negedge clk);
    while (busy && w < 20) begin
      tick();
      @(negedge clk);
      w++;
    end
    check("rr_idle", {63'd0, busy}, 64'd0);
    tick();

    xfer(1'b1, 1'b1, 16'h0100, 2'b11, 64'h1122334455667788, 64'd0, "st8");
    xfer(1'b0, 1'b0, 16'h0020, 2'b10, 64'd0, 64'h00000000DDCCBBAA, "ld_f4");
    xfer(1'b1, 1'b1, 16'hFFFF, 2'b01, 64'h000000000000BEEF, 64'd0, "st_wrap");
    xfer(1'b1, 1'b0, 16'hFFFC, 2'b11, 64'd0, 64'h060504BEEF030201, "ld_wrap");
    xfer(1'b1, 1'b0, 16'h0100, 2'b11, 64'd0, 64'h1122334455667788, "ld_back");
    xfer(1'b1, 1'b0, 16'h0200, 2'b00, 64'd0, 64'h000000000000005A, "ld_rr");

    // reset in the middle of an 8-byte store, after three bytes
    d_req = 1'b1; d_we = 1'b1; d_add = 16'h0300; d_sz = 2'b11; d_wd = 64'h8877665544332211;
    @(negedge clk);
    check("ab_gnt", {63'd0, d_gnt}, 64'd1);
    tick();
    d_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("ab_byte2", {47'd0, ram_we, ram_add}, {47'd0, 1'b1, 16'h0302});
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ab_we", {63'd0, ram_we}, 64'd0);
    check("ab_busy", {63'd0, busy}, 64'd0);
    check("ab_ram", {40'd0, ram_add, ram_d}, 64'd0);
    check("ab_iq", i_q, 64'd0);
    check("ab_dq", d_q, 64'd0);
    ab_dn = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (d_done || busy) ab_dn++;
    end
    check("ab_quiet", 64'(ab_dn), 64'd0);
    tick();
    xfer(1'b1, 1'b0, 16'h0300, 2'b11, 64'd0, 64'h0000000000332211, "ld_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
